atm_readback: RTL and testbench
===============================

ATM_READBACK -- requirements
Module: atm_readback

Interface
REQ-001 SHALL have port: fclk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; one clock, synchronous, active-high.
REQ-003 SHALL have ports: zpos, zneg  input  1 each  Z80 clock edge strobes, one fclk wide.
REQ-004 SHALL have ports: za  input  16  Z80 address; iorq_n, rd_n, m1_n  input  1 each  Z80 controls.
REQ-005 SHALL have port: shadow  input  1  shadow/DOS mode indicator, used only under RDBK_SHADOW_EN.
REQ-006 SHALL have ports: pg0_w  input  32  map-0 page of windows 3..0 (8 bits each, window n at [8n+7:8n]); pg1_w  input  32  map-1 pages, same packing.
REQ-007 SHALL have ports: ramnrom_w, dos7ffd_w, wrdis_w  input  8 each  per-window bit pairs {map1,map0}, window n at [2n+1:2n].
REQ-008 SHALL have ports: rd_data  output  8  read-back byte; rd_oe  output  1  drive Z80 data bus; rd_stb  output  1  one-fclk capture pulse.

Function
REQ-009 SHALL define the request term req = !iorq_n & !rd_n & m1_n & (za[7:0]==8'hBE), sampled into req_q only on fclk cycles with zpos=1.
REQ-010 SHALL implement states IDLE, CAPT, HOLD; IDLE->CAPT when req_q rises (0->1 across zpos samples).
REQ-011 SHALL, in CAPT, load rd_data from the select mux, pulse rd_stb for exactly that one fclk, and go to HOLD next fclk.
REQ-012 SHALL assert rd_oe from the fclk after CAPT through HOLD; rd_data SHALL remain constant while rd_oe=1.
REQ-013 SHALL leave HOLD for IDLE on the fclk after a zpos sample with req=0; rd_oe SHALL drop on that transition.
REQ-014 SHALL select by H=za[15:8] latched at CAPT: H=0x00..0x03 -> ~pg0_w window H[1:0]; H=0x04..0x07 -> ~pg1_w window H[1:0].
REQ-015 SHALL return H=0x08 -> ramnrom_w, H=0x09 -> dos7ffd_w, H=0x0A -> ~wrdis_w; all other H -> 8'hFF.
REQ-016 SHALL snapshot pre-update inputs if a pager write changes them in the CAPT cycle; later changes SHALL NOT alter rd_data during HOLD.
REQ-017 SHALL ignore zneg for state transitions.
REQ-018 SHALL NOT re-capture within one I/O cycle: a new CAPT requires req_q to return to 0 first.

Reset
REQ-019 SHALL on rst=1 force state IDLE, req_q=0, rd_data=8'hFF, rd_oe=0, rd_stb=0, regardless of current state.
REQ-020 SHALL, after rst deasserts mid I/O cycle, not respond until req_q is seen 0 then 1.

Configuration
REQ-021 SHALL recognise macro RDBK_SHADOW_EN: when defined, req SHALL additionally require shadow=1; when undefined, shadow SHALL be ignored and readback always enabled.

Structure
REQ-022 SHALL place port low byte 8'hBE, the H index constants (0x00, 0x04, 0x08, 0x09, 0x0A) and the state encoding in shared package atm_rdbk_pkg.
REQ-023 SHALL implement the combinational H-to-byte selection as sub-module atm_rdbk_mux; FSM and registers stay in atm_readback.

Verification
REQ-024 SHALL cover: pg0_w[15:8]=8'hC3, IN from 0x01BE -> one rd_stb, rd_data=8'h3C, rd_oe high until rd_n rises.
REQ-025 SHALL cover: ramnrom_w=8'hA5, IN from 0x08BE -> rd_data=8'hA5; IN from 0x0BBE -> rd_data=8'hFF.
REQ-026 SHALL cover: wrdis_w change 8'h00->8'hFF one fclk after CAPT, IN 0x0ABE -> rd_data stays 8'hFF throughout HOLD.
REQ-027 SHALL cover: rst=1 pulse during HOLD -> rd_oe=0, rd_data=8'hFF next fclk; no rd_stb until next separate IN cycle.
REQ-028 SHALL cover: RDBK_SHADOW_EN defined, shadow=0, IN 0x00BE -> no rd_stb, rd_oe=0; shadow=1 -> normal response.
REQ-029 SHALL cover: M1 cycle (m1_n=0) with za[7:0]=8'hBE and iorq_n=0 -> no response; IN to 0x00BF -> no response.

Source files
------------

// File: rtl/atm_rdbk_pkg.sv
// Shared constants for the ATM pager read-back port: port low byte, H-index map, FSM encoding.
// Used by atm_readback and atm_rdbk_mux (optional macro RDBK_SHADOW_EN is handled in the top).
package atm_rdbk_pkg;

    localparam logic [7:0] RDBK_PORT_LO = 8'hBE;

    localparam logic [7:0] H_PG0     = 8'h00;
    localparam logic [7:0] H_PG1     = 8'h04;
    localparam logic [7:0] H_RAMNROM = 8'h08;
    localparam logic [7:0] H_DOS7FFD = 8'h09;
    localparam logic [7:0] H_WRDIS   = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAPT = 2'd1,
        ST_HOLD = 2'd2
    } rdbk_state_e;

endpackage

// File: rtl/atm_rdbk_mux.sv
// Combinational H-index to read-back byte selection for the ATM pager read-back port.
// Page and write-disable registers are returned inverted; unmapped indices read as 8'hFF.
module atm_rdbk_mux
    import atm_rdbk_pkg::*;
(
    input  logic [7:0]  h,
    input  logic [31:0] pg0_w,
    input  logic [31:0] pg1_w,
    input  logic [7:0]  ramnrom_w,
    input  logic [7:0]  dos7ffd_w,
    input  logic [7:0]  wrdis_w,
    output logic [7:0]  rd_byte
);

    logic [4:0] win_lsb;

    assign win_lsb = {h[1:0], 3'b000};

    // NOTE: default assignment first so no path through the block can infer a latch.
    always_comb begin
        rd_byte = 8'hFF;
        if (h[7:2] == H_PG0[7:2]) begin
            rd_byte = ~pg0_w[win_lsb +: 8];
        end else if (h[7:2] == H_PG1[7:2]) begin
            rd_byte = ~pg1_w[win_lsb +: 8];
        end else if (h == H_RAMNROM) begin
            rd_byte = ramnrom_w;
        end else if (h == H_DOS7FFD) begin
            rd_byte = dos7ffd_w;
        end else if (h == H_WRDIS) begin
            rd_byte = ~wrdis_w;
        end
    end

endmodule

// File: rtl/atm_readback.sv
// ATM pager read-back port (IN from xxBE): captures one byte per Z80 I/O read cycle and holds it.
// Define RDBK_SHADOW_EN to make the port respond only while shadow=1.
module atm_readback
    import atm_rdbk_pkg::*;
(
    input  logic        fclk,
    input  logic        rst,
    input  logic        zpos,
    input  logic        zneg,
    input  logic [15:0] za,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        m1_n,
    input  logic        shadow,
    input  logic [31:0] pg0_w,
    input  logic [31:0] pg1_w,
    input  logic [7:0]  ramnrom_w,
    input  logic [7:0]  dos7ffd_w,
    input  logic [7:0]  wrdis_w,
    output logic [7:0]  rd_data,
    output logic        rd_oe,
    output logic        rd_stb
);

    rdbk_state_e state_q, state_d;
    logic        req_q, req_d;
    logic        armed_q, armed_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        req_io;
    logic        req;
    logic        req_rise;
    logic [7:0]  mux_byte;
    logic        unused_inputs;

    assign req_io = !iorq_n && !rd_n && m1_n && (za[7:0] == RDBK_PORT_LO);

`ifdef RDBK_SHADOW_EN
    assign req           = req_io && shadow;
    assign unused_inputs = zneg;
`else
    assign req           = req_io;
    assign unused_inputs = zneg ^ shadow;
`endif

    atm_rdbk_mux u_mux (
        .h         (za[15:8]),
        .pg0_w     (pg0_w),
        .pg1_w     (pg1_w),
        .ramnrom_w (ramnrom_w),
        .dos7ffd_w (dos7ffd_w),
        .wrdis_w   (wrdis_w),
        .rd_byte   (mux_byte)
    );

    // NOTE: all state uses non-blocking assignments; reset is synchronous and also clears the data latch.
    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            armed_q   <= 1'b0;
            rd_data_q <= 8'hFF;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            armed_q   <= armed_d;
            rd_data_q <= rd_data_d;
        end
    end

    // armed_q blocks a response to an I/O cycle already in progress when reset released.
    always_comb begin
        req_d    = zpos ? req : req_q;
        armed_d  = armed_q || (zpos && !req);
        req_rise = zpos && req && !req_q && armed_q;
        state_d  = state_q;
        case (state_q)
            ST_IDLE: if (req_rise) state_d = ST_CAPT;
            ST_CAPT: state_d = ST_HOLD;
            ST_HOLD: if (zpos && !req) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_data_d = (state_q == ST_CAPT) ? mux_byte : rd_data_q;
        rd_stb    = (state_q == ST_CAPT);
        rd_oe     = (state_q == ST_HOLD);
        rd_data   = rd_data_q;
    end

endmodule

// File: tb/tb_atm_readback.sv
// Self-checking bench for atm_readback: directed I/O cycles plus randomized transactions
// checked against a transaction-level model of the read-back port.
module tb_atm_readback;

`ifdef RDBK_SHADOW_EN
    localparam bit SHADOW_EN = 1'b1;
`else
    localparam bit SHADOW_EN = 1'b0;
`endif

    logic        fclk = 1'b0;
    logic        rst, zpos, zneg, iorq_n, rd_n, m1_n, shadow;
    logic [15:0] za;
    logic [31:0] pg0_w, pg1_w;
    logic [7:0]  ramnrom_w, dos7ffd_w, wrdis_w;
    logic [7:0]  rd_data;
    logic        rd_oe, rd_stb;

    int total = 0;
    int bad   = 0;
    int ph    = 0;

    int         stb_cnt      = 0;
    int         unstable_cnt = 0;
    int         oe_windows   = 0;
    logic [7:0] first_data   = 8'h00;
    bit         prev_oe      = 1'b0;

    atm_readback dut (
        .fclk      (fclk),
        .rst       (rst),
        .zpos      (zpos),
        .zneg      (zneg),
        .za        (za),
        .iorq_n    (iorq_n),
        .rd_n      (rd_n),
        .m1_n      (m1_n),
        .shadow    (shadow),
        .pg0_w     (pg0_w),
        .pg1_w     (pg1_w),
        .ramnrom_w (ramnrom_w),
        .dos7ffd_w (dos7ffd_w),
        .wrdis_w   (wrdis_w),
        .rd_data   (rd_data),
        .rd_oe     (rd_oe),
        .rd_stb    (rd_stb)
    );

    always #5 fclk = ~fclk;

    // Output monitor: strobe count, per-window first byte, and changes of rd_data while driven.
    always @(posedge fclk) begin
        #1;
        if (rd_stb === 1'b1) stb_cnt++;
        if (rd_oe === 1'b1) begin
            if (!prev_oe) begin
                first_data = rd_data;
                oe_windows++;
            end else if (rd_data !== first_data) begin
                unstable_cnt++;
            end
        end
        prev_oe = (rd_oe === 1'b1);
    end

    function automatic logic [7:0] model_byte(input int h, input logic [31:0] p0, input logic [31:0] p1,
                                              input logic [7:0] rn, input logic [7:0] d7, input logic [7:0] wd);
        if (h < 4)  return ~8'(p0 >> (8 * h));
        if (h < 8)  return ~8'(p1 >> (8 * (h - 4)));
        if (h == 8) return rn;
        if (h == 9) return d7;
        if (h == 10) return ~wd;
        return 8'hFF;
    endfunction

    function automatic bit model_resp(input logic [15:0] addr, input logic m1_v, input logic rd_v, input logic sh);
        return (m1_v == 1'b1) && (rd_v == 1'b0) && (addr[7:0] == 8'hBE) && (!SHADOW_EN || sh == 1'b1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One fclk; zpos/zneg model a Z80 clock at a quarter of fclk.
    task automatic tick();
        @(negedge fclk);
        zpos = (ph == 0);
        zneg = (ph == 2);
        ph   = (ph + 1) % 4;
    endtask

    task automatic do_io(input string tag, input logic [15:0] addr, input logic m1_v, input logic rd_v,
                         input logic sh, input bit force_wrdis, input bit rst_in_hold);
        logic [7:0] exp_b;
        bit         exp_r;
        int         s0, u0, w0, stb_at_rst;
        bit         seen_stb = 1'b0;
        bit         mutated  = 1'b0;
        bit         did_rst  = 1'b0;
        logic       oe_rel   = 1'b0;

        exp_r = model_resp(addr, m1_v, rd_v, sh);
        exp_b = model_byte(int'(addr[15:8]), pg0_w, pg1_w, ramnrom_w, dos7ffd_w, wrdis_w);
        s0 = stb_cnt;
        u0 = unstable_cnt;
        w0 = oe_windows;
        stb_at_rst = 0;

        za = addr; shadow = sh; m1_n = m1_v; rd_n = rd_v; iorq_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (seen_stb && !mutated) begin
                pg0_w     = $urandom;
                pg1_w     = $urandom;
                ramnrom_w = 8'($urandom);
                dos7ffd_w = 8'($urandom);
                wrdis_w   = force_wrdis ? 8'hFF : 8'($urandom);
                mutated   = 1'b1;
            end
            if (rd_stb === 1'b1) seen_stb = 1'b1;
            if (rst_in_hold && !did_rst && rd_oe === 1'b1) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check({tag, "_rst_oe"},   32'(rd_oe),   32'd0);
                check({tag, "_rst_data"}, 32'(rd_data), 32'hFF);
                check({tag, "_rst_stb"},  32'(rd_stb),  32'd0);
                did_rst    = 1'b1;
                stb_at_rst = stb_cnt;
            end
            oe_rel = rd_oe;
        end
        iorq_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        check({tag, "_stb"}, 32'(stb_cnt - s0), exp_r ? 32'd1 : 32'd0);
        check({tag, "_oe_at_release"}, 32'(oe_rel), 32'(exp_r && !rst_in_hold));
        if (rst_in_hold) begin
            check({tag, "_rst_taken"}, 32'(did_rst), 32'(exp_r));
            if (did_rst) check({tag, "_no_restb"}, 32'(stb_cnt - stb_at_rst), 32'd0);
        end
        if (exp_r) begin
            check({tag, "_windows"}, 32'(oe_windows - w0), 32'd1);
            check({tag, "_data"}, 32'(first_data), 32'(exp_b));
        end
        check({tag, "_stable"}, 32'(unstable_cnt - u0), 32'd0);
        check({tag, "_oe_after"}, 32'(rd_oe), 32'd0);
    endtask

    initial begin
        logic [15:0] raddr;

        rst = 1'b1; zpos = 1'b0; zneg = 1'b0; za = 16'h0000;
        iorq_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1; shadow = 1'b0;
        pg0_w = 32'h0; pg1_w = 32'h0; ramnrom_w = 8'h0; dos7ffd_w = 8'h0; wrdis_w = 8'h0;
        for (int i = 0; i < 4; i++) tick();
        check("reset_data", 32'(rd_data), 32'hFF);
        check("reset_oe",   32'(rd_oe),   32'd0);
        check("reset_stb",  32'(rd_stb),  32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        pg0_w = 32'h0000_C300;
        do_io("pg0_w1", 16'h01BE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        ramnrom_w = 8'hA5;
        do_io("ramnrom", 16'h08BE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        ramnrom_w = 8'hA5;
        do_io("unmapped", 16'h0BBE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("unmapped_ff", 32'(first_data), 32'hFF);

        wrdis_w = 8'h00;
        do_io("wrdis_snap", 16'h0ABE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("wrdis_snap_ff", 32'(first_data), 32'hFF);

        pg0_w = $urandom;
        do_io("rst_hold", 16'h02BE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        pg1_w = $urandom;
        do_io("after_rst", 16'h07BE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        do_io("shadow0", 16'h00BE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_io("shadow1", 16'h00BE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        do_io("m1_cycle", 16'h00BE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_io("port_bf",  16'h00BF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            pg0_w     = $urandom;
            pg1_w     = $urandom;
            ramnrom_w = 8'($urandom);
            dos7ffd_w = 8'($urandom);
            wrdis_w   = 8'($urandom);
            raddr[15:8] = 8'($urandom_range(0, 15));
            raddr[7:0]  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hBE;
            do_io($sformatf("rand%0d", n), raddr,
                  1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 1)), 1'b0, ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
